mmu_pager: RTL and testbench

- Parametrised, clocked memory-management unit that translates per-process logical addresses to physical BRAM addresses.
- Each process owns a linked chain of physical pages. A per-process one-entry translation cache gives 1-cycle hits.
- On a miss the unit walks the chain; if the page is absent it optionally allocates a free page (allocate-on-miss).
- Sits between the CPU fetch/load/store stages and the dual-port RAM. It also releases all pages of a terminated process.

---
 rtl/mmu_pager.sv | 213 +++++++++++++++++++++
 tb/tb_mmu_pager.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_pager.sv
// Per-process paged address translation: one-entry translation cache per process,
// chain walk on miss, optional allocate-on-miss from a free-page scan, and bulk release.
module mmu_pager #(
    parameter int LADDR_W   = 16,
    parameter int PHYS_W    = 10,
    parameter int PAGE_BITS = 3,
    parameter int NPROC     = 8,
    parameter int PROC_W    = 3
) (
    input  logic                          clka,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [PROC_W-1:0]             req_proc,
    input  logic [LADDR_W-1:0]            req_addr,
    input  logic                          req_alloc,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [PHYS_W-1:0]             rsp_paddr,
    output logic                          rsp_fault,
    input  logic                          free_valid,
    input  logic [PROC_W-1:0]             free_proc,
    output logic                          busy,
    output logic [PHYS_W-PAGE_BITS:0]     free_count
);

    localparam int PPG_W     = PHYS_W - PAGE_BITS;
    localparam int NUM_PAGES = 2 ** PPG_W;
    localparam int LP_W      = LADDR_W - PAGE_BITS;

    localparam logic [PPG_W-1:0] PG_ONE   = 1;
    localparam logic [PPG_W:0]   CNT_ONE  = 1;
    localparam logic [PPG_W-1:0] SCAN_MAX = {PPG_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_WALK, S_SCAN, S_LINK, S_RESP, S_FREE
    } state_t;

    state_t state, state_n;

    // Page tables: page p < NPROC is permanently the head of process p.
    logic [LP_W-1:0]      lpage    [NUM_PAGES];
    logic [PPG_W-1:0]     nxt      [NUM_PAGES];
    logic                 has_next [NUM_PAGES];
    logic                 used     [NUM_PAGES];

    logic                 cache_v  [NPROC];
    logic [LP_W-1:0]      cache_lp [NPROC];
    logic [PPG_W-1:0]     cache_pp [NPROC];

    logic [PROC_W-1:0]    q_proc;
    logic [LP_W-1:0]      q_lp;
    logic [PAGE_BITS-1:0] q_off;
    logic                 q_alloc;
    logic [PPG_W-1:0]     cur;
    logic [PPG_W-1:0]     scan_ptr;
    logic [PPG_W-1:0]     scan_cnt;
    logic                 fr_more;

    logic [LP_W-1:0]      req_lp;
    logic [PAGE_BITS-1:0] req_off;
    logic [PPG_W-1:0]     head_r, head_f, head_q;
    logic                 hit, lp_match, cur_end, scan_free, scan_last;

    assign req_lp  = req_addr[LADDR_W-1:PAGE_BITS];
    assign req_off = req_addr[PAGE_BITS-1:0];
    assign head_r  = PPG_W'(req_proc);
    assign head_f  = PPG_W'(free_proc);
    assign head_q  = PPG_W'(q_proc);

    always_comb begin
        hit       = cache_v[req_proc] && (cache_lp[req_proc] == req_lp);
        lp_match  = (lpage[cur] == q_lp);
        cur_end   = !has_next[cur];
        scan_free = !used[scan_ptr];
        scan_last = (scan_cnt == SCAN_MAX);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (free_valid)     state_n = S_FREE;
                else if (req_valid) state_n = hit ? S_RESP : S_WALK;
            end
            S_WALK: begin
                if (lp_match)     state_n = S_RESP;
                else if (cur_end) state_n = q_alloc ? S_SCAN : S_RESP;
            end
            S_SCAN: begin
                if (scan_free)      state_n = S_LINK;
                else if (scan_last) state_n = S_RESP;
            end
            S_LINK:  state_n = S_RESP;
            S_RESP:  if (rsp_ready) state_n = S_IDLE;
            S_FREE:  if (!fr_more || cur_end) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Free has priority over a coincident request, so req is held off while free_valid.
    assign req_ready = (state == S_IDLE) && !free_valid;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PAGES; i++) begin
                lpage[i]    <= '0;
                nxt[i]      <= '0;
                has_next[i] <= 1'b0;
                used[i]     <= (i < NPROC);
            end
            for (int p = 0; p < NPROC; p++) begin
                cache_v[p]  <= 1'b0;
                cache_lp[p] <= '0;
                cache_pp[p] <= '0;
            end
            q_proc     <= '0;
            q_lp       <= '0;
            q_off      <= '0;
            q_alloc    <= 1'b0;
            cur        <= '0;
            scan_ptr   <= PPG_W'(NPROC);
            scan_cnt   <= '0;
            fr_more    <= 1'b0;
            rsp_paddr  <= '0;
            rsp_fault  <= 1'b0;
            free_count <= (PPG_W+1)'(NUM_PAGES - NPROC);
        end else begin
            case (state)
                S_IDLE: begin
                    if (free_valid) begin
                        q_proc  <= free_proc;
                        fr_more <= has_next[head_f];
                        cur     <= nxt[head_f];
                    end else if (req_valid) begin
                        q_proc   <= req_proc;
                        q_lp     <= req_lp;
                        q_off    <= req_off;
                        q_alloc  <= req_alloc;
                        cur      <= head_r;
                        scan_cnt <= '0;
                        if (hit) begin
                            rsp_paddr <= {cache_pp[req_proc], req_off};
                            rsp_fault <= 1'b0;
                        end
                    end
                end
                S_WALK: begin
                    if (lp_match) begin
                        rsp_paddr        <= {cur, q_off};
                        rsp_fault        <= 1'b0;
                        cache_v[q_proc]  <= 1'b1;
                        cache_lp[q_proc] <= q_lp;
                        cache_pp[q_proc] <= cur;
                    end else if (cur_end) begin
                        if (!q_alloc) begin
                            rsp_paddr <= '0;
                            rsp_fault <= 1'b1;
                        end
                    end else begin
                        cur <= nxt[cur];
                    end
                end
                S_SCAN: begin
                    // On success scan_ptr stays put and names the page LINK will claim.
                    if (!scan_free) begin
                        scan_ptr <= scan_ptr + PG_ONE;
                        scan_cnt <= scan_cnt + PG_ONE;
                        if (scan_last) begin
                            rsp_paddr <= '0;
                            rsp_fault <= 1'b1;
                        end
                    end
                end
                S_LINK: begin
                    nxt[cur]           <= scan_ptr;
                    has_next[cur]      <= 1'b1;
                    used[scan_ptr]     <= 1'b1;
                    lpage[scan_ptr]    <= q_lp;
                    has_next[scan_ptr] <= 1'b0;
                    free_count         <= free_count - CNT_ONE;
                    scan_ptr           <= scan_ptr + PG_ONE;
                    cache_v[q_proc]    <= 1'b1;
                    cache_lp[q_proc]   <= q_lp;
                    cache_pp[q_proc]   <= scan_ptr;
                    rsp_paddr          <= {scan_ptr, q_off};
                    rsp_fault          <= 1'b0;
                end
                S_FREE: begin
                    if (fr_more) begin
                        used[cur]  <= 1'b0;
                        free_count <= free_count + CNT_ONE;
                        if (cur < scan_ptr) scan_ptr <= cur;
                        if (!cur_end) cur <= nxt[cur];
                    end
                    if (!fr_more || cur_end) begin
                        has_next[head_q] <= 1'b0;
                        cache_v[q_proc]  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_pager.sv
// Randomized bench for mmu_pager: a chain/free-list reference model predicts each
// response, its latency and the free page count; directed steps pin the model.
module tb_mmu_pager;

    localparam int LADDR_W   = 16;
    localparam int PHYS_W    = 10;
    localparam int PAGE_BITS = 3;
    localparam int NPROC     = 8;
    localparam int PROC_W    = 3;
    localparam int PPG_W     = PHYS_W - PAGE_BITS;
    localparam int NP        = 2 ** PPG_W;
    localparam int PAGE      = 2 ** PAGE_BITS;

    logic                 clka, rst;
    logic                 req_valid, req_ready, req_alloc;
    logic [PROC_W-1:0]    req_proc;
    logic [LADDR_W-1:0]   req_addr;
    logic                 rsp_valid, rsp_ready, rsp_fault;
    logic [PHYS_W-1:0]    rsp_paddr;
    logic                 free_valid, busy;
    logic [PROC_W-1:0]    free_proc;
    logic [PPG_W:0]       free_count;

    mmu_pager #(.LADDR_W(LADDR_W), .PHYS_W(PHYS_W), .PAGE_BITS(PAGE_BITS),
                .NPROC(NPROC), .PROC_W(PROC_W)) dut (
        .clka(clka), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_proc(req_proc),
        .req_addr(req_addr), .req_alloc(req_alloc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
        .rsp_fault(rsp_fault), .free_valid(free_valid), .free_proc(free_proc),
        .busy(busy), .free_count(free_count)
    );

    // clock / reset
    initial clka = 1'b0;
    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    // scoreboard: {fault, paddr} of the response currently owed
    logic [PHYS_W:0] exp_q[$];

    // reference model: chains as ordered page lists per process
    int ch     [NPROC][NP];
    int ch_len [NPROC];
    bit m_used [NP];
    int m_lp   [NP];
    int m_free, m_scan;
    bit c_v    [NPROC];
    int c_lp   [NPROC];
    int c_pp   [NPROC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_used[i] = (i < NPROC);
            m_lp[i]   = 0;
        end
        for (int p = 0; p < NPROC; p++) begin
            ch[p][0]  = p;
            ch_len[p] = 1;
            c_v[p]    = 0;
        end
        m_free = NP - NPROC;
        m_scan = NPROC;
    endtask

    task automatic model_req(input int p, input int addr, input bit alloc,
                             output int e_pa, output int e_f, output int e_lat);
        int lp, off, found, n, pg, len;
        lp = addr / PAGE;
        off = addr % PAGE;
        e_pa = 0;
        e_f = 0;
        e_lat = 0;
        len = ch_len[p];
        if (c_v[p] && c_lp[p] == lp) begin
            e_pa = c_pp[p] * PAGE + off;
            return;
        end
        found = -1;
        for (int i = 0; i < len; i++)
            if (found < 0 && m_lp[ch[p][i]] == lp) found = i;
        if (found >= 0) begin
            pg = ch[p][found];
            e_pa = pg * PAGE + off;
            e_lat = found + 1;
            c_v[p] = 1; c_lp[p] = lp; c_pp[p] = pg;
            return;
        end
        if (!alloc) begin
            e_f = 1;
            e_lat = len;
            return;
        end
        n = -1;
        for (int i = 0; i < NP; i++)
            if (n < 0 && !m_used[(m_scan + i) % NP]) n = i;
        if (n < 0) begin
            e_f = 1;
            e_lat = len + NP;
            return;
        end
        pg = (m_scan + n) % NP;
        m_used[pg] = 1;
        m_lp[pg] = lp;
        ch[p][len] = pg;
        ch_len[p] = len + 1;
        m_free--;
        m_scan = (pg + 1) % NP;
        c_v[p] = 1; c_lp[p] = lp; c_pp[p] = pg;
        e_pa = pg * PAGE + off;
        e_lat = len + n + 2;
    endtask

    task automatic model_free(input int p, output int pages);
        pages = ch_len[p] - 1;
        for (int i = 1; i < ch_len[p]; i++) begin
            m_used[ch[p][i]] = 0;
            m_free++;
            if (ch[p][i] < m_scan) m_scan = ch[p][i];
        end
        ch_len[p] = 1;
        c_v[p] = 0;
    endtask

    // compare process: response against scoreboard, free_count against model when idle
    always @(negedge clka) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else check("rsp_fault_paddr", 32'({rsp_fault, rsp_paddr}), 32'(exp_q[0]));
            end
            if (!busy) check("free_count", 32'(free_count), 32'(m_free));
        end
    end

    // driver tasks
    task automatic do_req(input int p, input int addr, input bit alloc, input int hold,
                          output logic [PHYS_W-1:0] got_pa, output logic got_f);
        int e_pa, e_f, e_lat, lat;
        @(posedge clka);
        #1;
        req_valid = 1'b1;
        req_proc  = PROC_W'(p);
        req_addr  = LADDR_W'(addr);
        req_alloc = alloc;
        #1;
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clka);
        model_req(p, addr, alloc, e_pa, e_f, e_lat);
        exp_q.push_back({1'(e_f), PHYS_W'(e_pa)});
        #1;
        req_valid = 1'b0;
        lat = 0;
        @(negedge clka);
        while (!rsp_valid && lat < 600) begin
            @(negedge clka);
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(e_lat));
        got_pa = rsp_paddr;
        got_f  = rsp_fault;
        repeat (hold) @(posedge clka);
        #1;
        rsp_ready = 1'b1;
        @(posedge clka);
        #1;
        rsp_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_free(input int p, input bit with_req);
        int pages, n;
        @(posedge clka);
        #1;
        free_valid = 1'b1;
        free_proc  = PROC_W'(p);
        if (with_req) begin
            req_valid = 1'b1;
            req_proc  = PROC_W'($urandom_range(0, NPROC - 1));
            req_addr  = LADDR_W'($urandom_range(0, 127));
            req_alloc = 1'b1;
        end
        #1;
        check("req_ready_free", 32'(req_ready), 32'd0);
        @(posedge clka);
        model_free(p, pages);
        #1;
        free_valid = 1'b0;
        req_valid  = 1'b0;
        n = 0;
        @(negedge clka);
        while (busy && n < 400) begin
            @(negedge clka);
            n++;
        end
        check("free_cycles", 32'(n), 32'((pages > 0) ? pages : 1));
    endtask

    logic [PHYS_W-1:0] pa;
    logic              f;
    int                r, p, lp;

    initial begin
        req_valid = 0; req_proc = 0; req_addr = 0; req_alloc = 0;
        rsp_ready = 0; free_valid = 0; free_proc = 0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_rsp_paddr", 32'(rsp_paddr), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_free_count", 32'(free_count), 32'd120);
        @(negedge clka);
        rst = 1'b0;

        // directed: walk hit on head, then cache hit
        do_req(2, 'h0005, 0, 0, pa, f);
        check("p2_paddr", 32'(pa), 32'h015);
        check("p2_fault", 32'(f), 32'd0);
        do_req(2, 'h0005, 0, 0, pa, f);
        check("p2_hit_paddr", 32'(pa), 32'h015);

        // allocate-on-miss picks page 8
        do_req(0, 'h0013, 1, 0, pa, f);
        check("p0_alloc_paddr", 32'(pa), 32'h043);
        check("model_free_119", 32'(m_free), 32'd119);

        // miss without alloc faults, tables untouched
        do_req(0, 'h0020, 0, 1, pa, f);
        check("p0_miss_fault", 32'(f), 32'd1);
        check("p0_miss_paddr", 32'(pa), 32'd0);

        // fill memory from proc 1, then one more must fault after a full scan
        for (int i = 1; i <= 119; i++)
            do_req(1, i * PAGE + int'($urandom_range(0, PAGE - 1)), 1, 0, pa, f);
        check("full_free_count", 32'(free_count), 32'd0);
        do_req(1, 120 * PAGE, 1, 0, pa, f);
        check("full_fault", 32'(f), 32'd1);
        check("full_paddr", 32'(pa), 32'd0);
        for (int i = 0; i < 10; i++) begin
            lp = $urandom_range(0, 125);
            do_req(1, lp * PAGE + 3, 0, 0, pa, f);
        end

        // release, then page 8 is handed out again; stall the response
        do_free(0, 0);
        do_free(1, 0);
        check("after_free_count", 32'(free_count), 32'd120);
        do_req(3, 'h0008, 1, 5, pa, f);
        check("p3_realloc_paddr", 32'(pa), 32'h040);
        do_free(5, 0);

        // coincident free and request: free wins
        do_free(3, 1);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            p = $urandom_range(0, NPROC - 1);
            if (r < 6) begin
                do_free(p, 0);
            end else if (r < 9) begin
                do_free(p, 1);
            end else begin
                lp = ($urandom_range(0, 15) == 0) ? 8190 : $urandom_range(0, 12);
                do_req(p, lp * PAGE + int'($urandom_range(0, PAGE - 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), pa, f);
            end
        end

        // reset while scanning for a free page
        do_free(0, 0);
        @(posedge clka);
        #1;
        req_valid = 1'b1; req_proc = 0; req_addr = 'h0013; req_alloc = 1'b1;
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        @(posedge clka);
        #2;
        check("busy_in_scan", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("arst_rsp_paddr", 32'(rsp_paddr), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_free_count", 32'(free_count), 32'd120);
        model_reset();
        exp_q.delete();
        @(negedge clka);
        rst = 1'b0;
        do_req(0, 'h0013, 1, 0, pa, f);
        check("post_rst_paddr", 32'(pa), 32'h043);
        @(negedge clka);
        check("post_rst_free_count", 32'(free_count), 32'd119);

        repeat (3) @(posedge clka);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
